// File: rtl/xor_pkg.sv
// Shared types, constants and sizing helpers for the streaming XOR parity accumulator.
package xor_pkg;

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [0:0] ST_ACCUM = ACCUM;
  localparam logic [0:0] ST_HOLD  = HOLD;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Bits needed to hold a beat count from 0 up to and including max_count.
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational XOR-reduction of a WIDTH-bit vector; the parametrised form of a multi-input XOR gate.
module xor_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             parity
);

  assign parity = ^vec;

endmodule

// File: rtl/xor_parity_accumulator.sv
// Streams WIDTH-bit beats over valid/ready, XOR-accumulates each lane across a frame and
// presents per-lane column parity, overall parity, beat count and early-close flag per frame.
module xor_parity_accumulator
  import xor_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FRAME_LEN  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_lane_parity,
  output logic                                out_parity,
  output logic [count_width(FRAME_LEN)-1:0]   out_count,
  output logic                                out_early,
  output logic [0:0]                          dbg_state
);

  localparam int            CW         = count_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_LEN);
  localparam logic          PAR_SENSE  = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  // Handshake: a beat moves when in_valid && in_ready; a result moves when
  // out_valid && out_ready. in_ready opens as soon as the held result is being taken.
  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             in_fire;
  logic             out_fire;
  logic             closing;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;
  logic             lane_xor;

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign acc_next  = acc ^ in_data;
  assign cnt_next  = cnt + CW'(1);
  assign closing   = in_fire && (in_last || (cnt_next == LAST_COUNT));
  assign dbg_state = state;

  xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .vec    (acc_next),
    .parity (lane_xor)
  );

  // acc/cnt are zero while a result is held, so a beat taken on the accept
  // cycle naturally starts the next frame from in_data with a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_ACCUM;
      acc             <= '0;
      cnt             <= '0;
      out_lane_parity <= '0;
      out_parity      <= 1'b0;
      out_count       <= '0;
      out_early       <= 1'b0;
    end else if (closing) begin
      state           <= ST_HOLD;
      acc             <= '0;
      cnt             <= '0;
      out_lane_parity <= acc_next;
      out_parity      <= lane_xor ^ PAR_SENSE;
      out_count       <= cnt_next;
      out_early       <= in_last && (cnt_next < LAST_COUNT);
    end else begin
      if (out_fire) begin
        state <= ST_ACCUM;
      end
      if (in_fire) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Directed bench for xor_parity_accumulator: even/odd FRAME_LEN=4 instances share stimulus,
// a FRAME_LEN=1 instance runs its own short sequence.
module tb_xor_parity_accumulator;

  localparam int W  = 4;
  localparam int FL = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for instances a (even) and b (odd)
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_out_valid, a_par, a_early;
  logic [W-1:0] a_lane;
  logic [2:0]   a_count;
  logic [0:0]   a_state;
  logic         b_in_ready, b_out_valid, b_par, b_early;
  logic [W-1:0] b_lane;
  logic [2:0]   b_count;
  logic [0:0]   b_state;

  // FRAME_LEN = 1 instance
  logic         c_in_valid, c_in_last, c_out_ready;
  logic [W-1:0] c_in_data;
  logic         c_in_ready, c_out_valid, c_par, c_early;
  logic [W-1:0] c_lane;
  logic [0:0]   c_count;
  logic [0:0]   c_state;

  xor_parity_accumulator #(.WIDTH(W), .FRAME_LEN(FL), .ODD_PARITY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_lane_parity(a_lane),
    .out_parity(a_par), .out_count(a_count), .out_early(a_early), .dbg_state(a_state));

  xor_parity_accumulator #(.WIDTH(W), .FRAME_LEN(FL), .ODD_PARITY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_lane_parity(b_lane),
    .out_parity(b_par), .out_count(b_count), .out_early(b_early), .dbg_state(b_state));

  xor_parity_accumulator #(.WIDTH(W), .FRAME_LEN(1), .ODD_PARITY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_lane_parity(c_lane),
    .out_parity(c_par), .out_count(c_count), .out_early(c_early), .dbg_state(c_state));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: frame contents as a queue, result computed from the whole frame
  logic [W-1:0] exp_q[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_lane  = '0;
  int           m_count = 0;
  logic         m_early = 1'b0;
  logic         m_par;
  logic         rdy, fire_in, fire_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_lane  = '0;
      m_count = 0;
      m_early = 1'b0;
    end
    m_par = ($countones(m_lane) % 2) == 1;
    chk("a_valid", a_out_valid, m_valid);
    chk("b_valid", b_out_valid, m_valid);
    chk("a_in_ready", a_in_ready, !m_valid || out_ready);
    chk("b_in_ready", b_in_ready, !m_valid || out_ready);
    chk("a_state", a_state, m_valid);
    if (m_valid || !rst_n) begin
      chk("a_lane", a_lane, m_lane);
      chk("b_lane", b_lane, m_lane);
      chk("a_count", a_count, m_count);
      chk("b_count", b_count, m_count);
      chk("a_early", a_early, m_early);
      chk("b_early", b_early, m_early);
      chk("a_par", a_par, rst_n ? m_par : 1'b0);
      chk("b_par", b_par, rst_n ? !m_par : 1'b0);
    end
    if (rst_n) begin
      rdy      = !m_valid || out_ready;
      fire_out = m_valid && out_ready;
      fire_in  = in_valid && rdy;
      if (fire_out) m_valid = 1'b0;
      if (fire_in) begin
        exp_q.push_back(in_data);
        if (exp_q.size() == FL || in_last) begin
          m_lane = '0;
          foreach (exp_q[i]) m_lane ^= exp_q[i];
          m_count = exp_q.size();
          m_early = in_last && (exp_q.size() < FL);
          m_valid = 1'b1;
          exp_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!a_in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!a_in_ready) chk("send_ready_bound", a_in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  task automatic c_send(input logic [W-1:0] d, input logic l);
    int waited = 0;
    c_in_valid = 1'b1;
    c_in_data  = d;
    c_in_last  = l;
    @(negedge clk);
    while (!c_in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!c_in_ready) chk("c_send_ready_bound", c_in_ready, 1'b1);
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
    c_in_data  = 'x;
    c_in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [W-1:0] lane, input logic par,
                              input int count, input logic early);
    chk({name, "_valid"}, a_out_valid, 1'b1);
    chk({name, "_lane"}, a_lane, lane);
    chk({name, "_par_even"}, a_par, par);
    chk({name, "_par_odd"}, b_par, !par);
    chk({name, "_count"}, a_count, count);
    chk({name, "_early"}, a_early, early);
  endtask

  task automatic check_c(input string name, input logic [W-1:0] d);
    chk({name, "_valid"}, c_out_valid, 1'b1);
    chk({name, "_lane"}, c_lane, d);
    chk({name, "_par"}, c_par, ($countones(d) % 2) == 1);
    chk({name, "_count"}, c_count, 1);
    chk({name, "_early"}, c_early, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;
    rst_n = 1'b0;
    tick(2);
    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_lane", a_lane, 4'b0000);
    chk("rst_par_even", a_par, 1'b0);
    chk("rst_par_odd", b_par, 1'b0);
    chk("rst_count", a_count, 0);
    chk("rst_early", a_early, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_c_valid", c_out_valid, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // full frame back-to-back
    send(4'b0001, 0); send(4'b0011, 0); send(4'b0111, 0); send(4'b1111, 0);
    check_result("full", 4'b1010, 1'b0, 4, 1'b0);
    tick(1);
    chk("full_drain", a_out_valid, 1'b0);

    // early close held under backpressure
    out_ready = 1'b0;
    send(4'b1000, 0); send(4'b0001, 1);
    check_result("early", 4'b1001, 1'b0, 2, 1'b1);
    chk("bp_in_ready", a_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_result("bp_hold", 4'b1001, 1'b0, 2, 1'b1);
      chk("bp_in_ready_hold", a_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_in_ready, 1'b1);
    tick(1);
    chk("bp_release_valid", a_out_valid, 1'b0);

    // new frame's beat accepted on the result-accept cycle
    send(4'b0001, 0); send(4'b0010, 0); send(4'b0100, 0); send(4'b1000, 0);
    check_result("b2b_first", 4'b1111, 1'b0, 4, 1'b0);
    send(4'b0111, 1);
    check_result("b2b_second", 4'b0111, 1'b1, 1, 1'b1);
    tick(1);
    chk("b2b_drain", a_out_valid, 1'b0);

    // in_last on the FRAME_LEN-th beat is a plain full frame
    send(4'b0001, 0); send(4'b0001, 0); send(4'b0001, 0); send(4'b0001, 1);
    check_result("last_on_full", 4'b0000, 1'b0, 4, 1'b0);
    tick(1);

    // reset mid-frame discards the partial frame
    send(4'b0001, 0); send(4'b0010, 0);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_valid", a_out_valid, 1'b0);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'b0001, 0);
    check_result("post_reset", 4'b0000, 1'b0, 4, 1'b0);

    // reset while a result is held clears outputs without a clock
    rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", a_out_valid, 1'b0);
    chk("hold_rst_count", a_count, 0);
    chk("hold_rst_par_odd", b_par, 1'b0);
    chk("hold_rst_in_ready", a_in_ready, 1'b1);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1);

    // idle gaps between beats give the contiguous result
    send(4'b0001, 0); tick(2);
    send(4'b0011, 0); tick(1);
    send(4'b0111, 0); tick(3);
    send(4'b1111, 0);
    check_result("gaps", 4'b1010, 1'b0, 4, 1'b0);
    tick(1);

    // FRAME_LEN = 1: every beat is its own frame
    c_send(4'b0101, 0); check_c("fl1_a", 4'b0101);
    c_send(4'b1010, 1); check_c("fl1_b", 4'b1010);
    c_send(4'b0111, 0); check_c("fl1_c", 4'b0111);
    tick(1);
    chk("fl1_drain", c_out_valid, 1'b0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_parity_accumulator.md
Name: xor_parity_accumulator

Overview:
- Parametrised, clocked generalisation of the four-input XOR gate.
- Accepts a stream of WIDTH-bit beats over a valid/ready handshake and XOR-accumulates each bit lane across a frame.
- Emits per-lane column parity plus overall (even/odd) parity when the frame closes.
- Used as a streaming parity generator/checker between stimulus sources and downstream consumers.

Parameters:
- WIDTH, 4, number of input bit lanes (>=1)
- FRAME_LEN, 8, maximum beats per frame (>=1)
- ODD_PARITY, 0, 0 = even parity, 1 = odd parity (inverts out_parity)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  WIDTH  input beat
- in_last  input  1  closes the frame early on this beat
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts result
- out_lane_parity  output  WIDTH  XOR of every accepted beat in the frame, per lane
- out_parity  output  1  XOR-reduction of out_lane_parity, XOR ODD_PARITY
- out_count  output  CW  beats in the frame; CW = clog2(FRAME_LEN+1)
- out_early  output  1  frame was closed by in_last before reaching FRAME_LEN beats

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - state = ACCUM
  - accumulator = 0, beat counter = 0
  - out_valid = 0, out_lane_parity = 0, out_parity = 0, out_count = 0, out_early = 0
  - in_ready = 1
- Transfers: an input beat transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational pass-through).
  - A new frame's first beat can be accepted in the same cycle its predecessor's result is taken.
- States:
  - ACCUM: accumulates beats.
    - On each transfer: acc <= acc ^ in_data and cnt <= cnt + 1.
    - If the transfer is the closing beat, go to HOLD.
  - HOLD: result registered and out_valid = 1.
    - Outputs stay stable until the output transfer.
    - On output transfer, return to ACCUM. If a beat transfers in that same cycle, it starts the new frame with acc <= in_data and cnt <= 1.
- Closing beat: a transfer with cnt+1 == FRAME_LEN, or a transfer with in_last = 1.
  - out_early = in_last && (cnt+1 < FRAME_LEN).
  - in_last on the FRAME_LEN-th beat gives out_early = 0.
- Latency: results appear on the cycle after the closing-beat edge. out_lane_parity = acc ^ in_data and out_count = cnt+1.
- Clear on close: the accumulator and counter clear on the closing edge, so the next frame starts from 0.
- Idle: in_valid low leaves acc and cnt unchanged; there is no timeout.
- in_data while in_valid = 0 is ignored, including X values.
- Reset mid-frame or mid-HOLD: the partial frame and pending result are discarded with no output. Outputs return to reset values asynchronously.
- Width rules:
  - out_count is CW bits wide and never exceeds FRAME_LEN.
  - The counter does not wrap within a frame.
  - FRAME_LEN = 1 makes every beat a frame with out_early = 0.
- Simultaneous in_last and the FRAME_LEN boundary count as a single close.

Decomposition:
- Package xor_pkg:
  - state enum {ACCUM, HOLD}
  - count-width helper function (clog2)
  - ODD/EVEN parity constants
- Sub-module xor_reduce (parameter WIDTH): combinational XOR-reduction of a WIDTH-bit vector.
  - Parametrised successor of the four-input XOR gate.
  - Instantiated for out_parity.

Test Plan (WIDTH=4, FRAME_LEN=4 unless noted):
- Full frame, ODD_PARITY=0: beats 0001, 0011, 0111, 1111 back-to-back -> one cycle after the 4th beat: out_lane_parity=1010, out_parity=0, out_count=4, out_early=0. Same stimulus with ODD_PARITY=1 -> out_parity=1.
- Early close: beats 1000, 0001 (in_last on the 2nd) -> out_lane_parity=1001, out_parity=0, out_count=2, out_early=1.
- Backpressure: out_ready held 0 for 3 cycles after out_valid -> out_valid stays 1, outputs unchanged, in_ready=0. out_ready=1 then clears out_valid the next cycle.
- Back-to-back frames: out_ready=1 and in_valid held high, with a new beat 0111 plus in_last on the result-accept cycle -> 2nd result one cycle later is 0111, out_parity=1, out_count=1, no lost beat.
- Reset mid-frame: 2 beats accepted, rst_n pulsed low -> all outputs 0 immediately. Next 4 beats of 0001 -> out_lane_parity=0000, out_count=4.
- Gaps and FRAME_LEN=1: in_valid toggling with idle cycles gives the same result as the contiguous case. With FRAME_LEN=1, every beat produces a result with out_count=1 and out_early=0.
